// File: rtl/ing_tuser_insert.sv
// rtl/ing_tuser_insert.sv - AXI-Stream ingress sideband insert with packet length policing
//
// Purpose: takes a plain MAC-side AXI stream and adds per-packet tid/tdest
// sidebands and a 1-bit tuser error flag. Runt packets (fewer than
// MIN_PKT_BEATS beats) get tuser=1 on their last beat. Packets that reach
// MAX_PKT_BEATS beats without tlast are cut: that beat leaves with tlast=1 and
// tuser=1, and the rest of the input packet is swallowed. The output is a
// single register stage with one cycle of latency and full throughput.
//
// Ports:
//   aclk, areset            clock, asynchronous active-high reset
//   axis_in_t*              input stream (tdata, tkeep, tlast, tvalid, tready)
//   pkt_tid, pkt_tdest      sidebands for the next packet, sampled on its first beat
//   axis_out_t*             output stream (tdata, tuser, tid, tdest, tkeep, tlast,
//                           tvalid, tready)
module ing_tuser_insert #(
  parameter int AXIS_BUS_WIDTH  = 64,
  parameter int AXIS_ID_WIDTH   = 4,
  parameter int AXIS_DEST_WIDTH = 0,
  parameter int MIN_PKT_BEATS   = 8,
  parameter int MAX_PKT_BEATS   = 190,
  localparam int KW  = AXIS_BUS_WIDTH / 8,
  localparam int IDW = (AXIS_ID_WIDTH > 0) ? AXIS_ID_WIDTH : 1,
  localparam int DW  = (AXIS_DEST_WIDTH > 0) ? AXIS_DEST_WIDTH : 1
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [AXIS_BUS_WIDTH-1:0] axis_in_tdata,
  input  logic [KW-1:0]             axis_in_tkeep,
  input  logic                      axis_in_tlast,
  input  logic                      axis_in_tvalid,
  output logic                      axis_in_tready,
  input  logic [IDW-1:0]            pkt_tid,
  input  logic [DW-1:0]             pkt_tdest,
  output logic [AXIS_BUS_WIDTH-1:0] axis_out_tdata,
  output logic                      axis_out_tuser,
  output logic [IDW-1:0]            axis_out_tid,
  output logic [DW-1:0]             axis_out_tdest,
  output logic [KW-1:0]             axis_out_tkeep,
  output logic                      axis_out_tlast,
  output logic                      axis_out_tvalid,
  input  logic                      axis_out_tready
);

  typedef enum logic [1:0] {S_SOP, S_MID, S_TRUNC} state_t;

  localparam logic [15:0] MIN_C = 16'(MIN_PKT_BEATS);
  localparam logic [15:0] MAX_C = 16'(MAX_PKT_BEATS);

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [15:0]               r_cnt;
  logic [15:0]               w_cnt;
  logic [AXIS_BUS_WIDTH-1:0] r_tdata;
  logic [KW-1:0]             r_tkeep;
  logic                      r_tlast;
  logic                      r_tuser;
  logic                      r_tvalid;
  logic [IDW-1:0]            r_tid;
  logic [DW-1:0]             r_tdest;
  logic [IDW-1:0]            w_tid;
  logic [DW-1:0]             w_tdest;
  logic                      w_in_ready;
  logic                      w_accept;
  logic                      w_emit;
  logic                      w_at_max;
  logic                      w_runt;

  // The discard state never touches the output register, so it can always
  // accept regardless of downstream backpressure.
  assign w_in_ready = (r_state == S_TRUNC) | ~r_tvalid | axis_out_tready;
  assign w_accept   = axis_in_tvalid & w_in_ready;
  assign w_emit     = w_accept & (r_state != S_TRUNC);

  // Beat number of the beat being accepted now, saturating at 16 bits.
  assign w_cnt = (r_state == S_SOP) ? 16'd1 :
                 (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;

  assign w_at_max = (w_cnt == MAX_C);
  assign w_runt   = (w_cnt < MIN_C);

  // After the first beat the output register already carries this packet's
  // sidebands, so it doubles as the per-packet latch and later changes on
  // the pkt_* ports are ignored until the next SOP.
  assign w_tid   = (AXIS_ID_WIDTH == 0) ? '0 :
                   (r_state == S_SOP) ? pkt_tid : r_tid;
  assign w_tdest = (AXIS_DEST_WIDTH == 0) ? '0 :
                   (r_state == S_SOP) ? pkt_tdest : r_tdest;

  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) begin
      case (r_state)
        S_SOP, S_MID: begin
          if (axis_in_tlast)   w_state_nxt = S_SOP;
          else if (w_at_max)   w_state_nxt = S_TRUNC;
          else                 w_state_nxt = S_MID;
        end
        S_TRUNC: begin
          if (axis_in_tlast)   w_state_nxt = S_SOP;
        end
        default:               w_state_nxt = S_SOP;
      endcase
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state <= S_SOP;
      r_cnt   <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_emit) r_cnt <= w_cnt;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_tdata  <= '0;
      r_tkeep  <= '0;
      r_tlast  <= 1'b0;
      r_tuser  <= 1'b0;
      r_tvalid <= 1'b0;
      r_tid    <= '0;
      r_tdest  <= '0;
    end else if (w_emit) begin
      r_tdata  <= axis_in_tdata;
      r_tkeep  <= axis_in_tkeep;
      // A beat reaching the limit without tlast closes the packet as an error.
      r_tlast  <= axis_in_tlast | w_at_max;
      r_tuser  <= axis_in_tlast ? w_runt : w_at_max;
      r_tvalid <= 1'b1;
      r_tid    <= w_tid;
      r_tdest  <= w_tdest;
    end else if (axis_out_tready) begin
      r_tvalid <= 1'b0;
    end
  end

  assign axis_in_tready  = w_in_ready;
  assign axis_out_tdata  = r_tdata;
  assign axis_out_tkeep  = r_tkeep;
  assign axis_out_tlast  = r_tlast;
  assign axis_out_tuser  = r_tuser;
  assign axis_out_tvalid = r_tvalid;
  assign axis_out_tid    = r_tid;
  assign axis_out_tdest  = r_tdest;

endmodule

// File: tb/tb_ing_tuser_insert.sv
// tb/tb_ing_tuser_insert.sv - directed bench for ing_tuser_insert
module tb_ing_tuser_insert;
  localparam int MINB = 8;
  localparam int MAXB = 190;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic        u;
    logic [3:0]  id;
    logic        dst;
  } beat_t;

  logic        aclk = 1'b0;
  logic        areset;
  logic [63:0] in_tdata;
  logic [7:0]  in_tkeep;
  logic        in_tlast, in_tvalid, in_tready;
  logic [3:0]  pkt_tid;
  logic [0:0]  pkt_tdest;
  logic [63:0] out_tdata;
  logic        out_tuser;
  logic [3:0]  out_tid;
  logic [0:0]  out_tdest;
  logic [7:0]  out_tkeep;
  logic        out_tlast, out_tvalid, out_tready;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    rdy_mode = 0;
  int    first_acc_cyc = -1;
  beat_t exp_q[$];
  beat_t obs_q[$];
  int    obs_cyc[$];

  ing_tuser_insert #(
    .AXIS_BUS_WIDTH(64), .AXIS_ID_WIDTH(4), .AXIS_DEST_WIDTH(0),
    .MIN_PKT_BEATS(MINB), .MAX_PKT_BEATS(MAXB)
  ) dut (
    .aclk(aclk), .areset(areset),
    .axis_in_tdata(in_tdata), .axis_in_tkeep(in_tkeep), .axis_in_tlast(in_tlast),
    .axis_in_tvalid(in_tvalid), .axis_in_tready(in_tready),
    .pkt_tid(pkt_tid), .pkt_tdest(pkt_tdest),
    .axis_out_tdata(out_tdata), .axis_out_tuser(out_tuser), .axis_out_tid(out_tid),
    .axis_out_tdest(out_tdest), .axis_out_tkeep(out_tkeep), .axis_out_tlast(out_tlast),
    .axis_out_tvalid(out_tvalid), .axis_out_tready(out_tready)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  initial begin
    out_tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      out_tready = (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  function automatic logic [63:0] mk_data(input int pkt, input int i);
    return {32'(pkt), 32'(i)};
  endfunction

  function automatic logic [7:0] mk_keep(input int pkt, input int i, input int len);
    return (i == len - 1) ? (8'hFF >> (pkt % 8)) : 8'hFF;
  endfunction

  task automatic push_exp(input int pkt, input int len, input logic [3:0] tid);
    beat_t b;
    int n;
    n = (len > MAXB) ? MAXB : len;
    for (int i = 0; i < n; i++) begin
      b.d   = mk_data(pkt, i);
      b.k   = mk_keep(pkt, i, len);
      b.l   = (i == n - 1);
      b.u   = (i == n - 1) && (len < MINB || len > MAXB);
      b.id  = tid;
      b.dst = 1'b0;
      exp_q.push_back(b);
    end
  endtask

  task automatic drive_pkt(input int pkt, input int len, input logic [3:0] tid, input bit gaps);
    bit acc;
    int wc;
    for (int i = 0; i < len; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_tvalid = 1'b0;
        @(posedge aclk);
        #1;
      end
      in_tvalid = 1'b1;
      in_tdata  = mk_data(pkt, i);
      in_tkeep  = mk_keep(pkt, i, len);
      in_tlast  = (i == len - 1);
      if (i == 0) begin
        pkt_tid   = tid;
        pkt_tdest = 1'($urandom_range(0, 1));
      end
      acc = 1'b0;
      wc  = 0;
      while (!acc && wc < 1000) begin
        @(negedge aclk);
        acc = in_tready;
        if (acc && i == 0 && first_acc_cyc < 0) first_acc_cyc = cyc;
        @(posedge aclk);
        #1;
        wc++;
      end
      if (!acc) begin
        checks++;
        errors++;
        $display("FAIL drive_timeout pkt %0d beat %0d: in_tready stayed 0, want 1", pkt, i);
        break;
      end
      if (i == 0) pkt_tid = ~tid;
    end
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
  endtask

  task automatic collect(input int n, input int budget);
    int k;
    k = 0;
    while (obs_q.size() < n && k < budget) begin
      @(negedge aclk);
      k++;
      if (out_tvalid && out_tready) begin
        obs_q.push_back({out_tdata, out_tkeep, out_tlast, out_tuser, out_tid, out_tdest});
        obs_cyc.push_back(cyc);
      end
    end
  endtask

  task automatic clear_q();
    exp_q.delete();
    obs_q.delete();
    obs_cyc.delete();
    first_acc_cyc = -1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    in_tvalid = 1'b0; in_tlast = 1'b0; in_tdata = '0; in_tkeep = '0;
    pkt_tid = '0; pkt_tdest = '0;
    idle(3);
    checks++;
    if (out_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b want 0", out_tvalid); end
    checks++;
    if (out_tdata !== 64'd0) begin errors++; $display("FAIL reset_tdata: got %h want 0", out_tdata); end
    checks++;
    if ({out_tkeep, out_tlast, out_tuser, out_tid, out_tdest} !== 15'd0) begin
      errors++;
      $display("FAIL reset_side: got keep=%h last=%b user=%b tid=%h dest=%b want all 0",
               out_tkeep, out_tlast, out_tuser, out_tid, out_tdest);
    end
    checks++;
    if (in_tready !== 1'b1) begin errors++; $display("FAIL reset_in_tready: got %b want 1", in_tready); end
    areset = 1'b0;
    idle(2);
    checks++;
    if (out_tvalid !== 1'b0) begin errors++; $display("FAIL post_reset_tvalid: got %b want 0", out_tvalid); end
  endtask

  task automatic test_back_to_back();
    clear_q();
    rdy_mode = 0;
    for (int p = 0; p < 4; p++) push_exp(100 + p, 8, 4'd3);
    fork
      for (int p = 0; p < 4; p++) drive_pkt(100 + p, 8, 4'd3, 1'b0);
      collect(32, 200);
    join
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL b2b_count: got %0d beats want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL b2b_beat %0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    if (obs_q.size() > 0) begin
      checks++;
      if (obs_cyc[0] != first_acc_cyc + 1) begin
        errors++; $display("FAIL b2b_latency: got cycle %0d want %0d", obs_cyc[0], first_acc_cyc + 1);
      end
    end
    for (int i = 1; i < obs_cyc.size(); i++) begin
      checks++;
      if (obs_cyc[i] != obs_cyc[i-1] + 1) begin
        errors++; $display("FAIL b2b_bubble beat %0d: got cycle %0d want %0d", i, obs_cyc[i], obs_cyc[i-1] + 1);
      end
    end
    idle(2);
  endtask

  task automatic test_runt();
    clear_q();
    rdy_mode = 0;
    push_exp(200, 3, 4'd5);
    push_exp(201, 1, 4'd6);
    fork
      begin drive_pkt(200, 3, 4'd5, 1'b0); drive_pkt(201, 1, 4'd6, 1'b0); end
      collect(4, 100);
    join
    checks++;
    if (obs_q.size() != 4) begin errors++; $display("FAIL runt_count: got %0d beats want 4", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL runt_beat %0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    if (obs_q.size() == 4) begin
      checks++;
      if ({obs_q[0].u, obs_q[1].u, obs_q[2].u, obs_q[2].l, obs_q[3].u, obs_q[3].l} !== 6'b001111) begin
        errors++;
        $display("FAIL runt_flags: got %b want 001111",
                 {obs_q[0].u, obs_q[1].u, obs_q[2].u, obs_q[2].l, obs_q[3].u, obs_q[3].l});
      end
    end
    idle(2);
  endtask

  task automatic test_truncate();
    clear_q();
    rdy_mode = 0;
    push_exp(300, 200, 4'd7);
    push_exp(301, 8, 4'd2);
    fork
      begin drive_pkt(300, 200, 4'd7, 1'b0); drive_pkt(301, 8, 4'd2, 1'b0); end
      collect(198, 600);
    join
    idle(4);
    checks++;
    if (obs_q.size() != 198) begin errors++; $display("FAIL trunc_count: got %0d beats want 198", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL trunc_beat %0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    if (obs_q.size() >= 191) begin
      checks++;
      if ({obs_q[189].l, obs_q[189].u, obs_q[188].l} !== 3'b110) begin
        errors++; $display("FAIL trunc_cut_beat: got last/user/prevlast %b want 110",
                           {obs_q[189].l, obs_q[189].u, obs_q[188].l});
      end
      checks++;
      if (obs_q[190].d !== {32'd301, 32'd0} || obs_q[190].id !== 4'd2) begin
        errors++; $display("FAIL trunc_next_sop: got d=%h tid=%h want d=%h tid=2",
                           obs_q[190].d, obs_q[190].id, {32'd301, 32'd0});
      end
    end
    checks++;
    if (out_tvalid !== 1'b0) begin errors++; $display("FAIL trunc_extra_output: got tvalid %b want 0", out_tvalid); end
  endtask

  task automatic test_max_legal();
    clear_q();
    rdy_mode = 0;
    push_exp(400, 190, 4'd9);
    push_exp(401, 9, 4'd1);
    fork
      begin drive_pkt(400, 190, 4'd9, 1'b0); drive_pkt(401, 9, 4'd1, 1'b0); end
      collect(199, 600);
    join
    checks++;
    if (obs_q.size() != 199) begin errors++; $display("FAIL max_count: got %0d beats want 199", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL max_beat %0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    idle(2);
  endtask

  task automatic test_random_stall();
    int    lens[1000];
    logic [3:0] tids[1000];
    int    k;
    int    nexp;
    bit    prev_stall;
    beat_t prev_b, cur;
    clear_q();
    for (int p = 0; p < 1000; p++) begin
      lens[p] = ($urandom_range(0, 49) == 0) ? int'($urandom_range(185, 195)) : int'($urandom_range(1, 12));
      tids[p] = 4'($urandom_range(0, 15));
      push_exp(1000 + p, lens[p], tids[p]);
    end
    nexp = exp_q.size();
    rdy_mode = 1;
    fork
      for (int p = 0; p < 1000; p++) drive_pkt(1000 + p, lens[p], tids[p], 1'b1);
      begin
        k = 0;
        prev_stall = 1'b0;
        while (obs_q.size() < nexp && k < 80000) begin
          @(negedge aclk);
          k++;
          cur = {out_tdata, out_tkeep, out_tlast, out_tuser, out_tid, out_tdest};
          if (prev_stall) begin
            checks++;
            if (out_tvalid !== 1'b1 || cur !== prev_b) begin
              errors++; $display("FAIL stall_stable: got valid=%b beat %h want valid=1 beat %h",
                                 out_tvalid, cur, prev_b);
            end
          end
          prev_stall = out_tvalid & ~out_tready;
          prev_b = cur;
          if (out_tvalid && out_tready) obs_q.push_back(cur);
        end
      end
    join
    rdy_mode = 0;
    checks++;
    if (obs_q.size() != nexp) begin errors++; $display("FAIL rand_count: got %0d beats want %0d", obs_q.size(), nexp); end
    for (int i = 0; i < nexp && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL rand_beat %0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    idle(3);
  endtask

  task automatic test_reset_midpacket();
    clear_q();
    rdy_mode = 0;
    pkt_tid = 4'd6;
    for (int i = 0; i < 3; i++) begin
      in_tvalid = 1'b1; in_tdata = mk_data(500, i); in_tkeep = 8'hFF; in_tlast = 1'b0;
      @(posedge aclk);
      #1;
    end
    in_tdata = mk_data(500, 3);
    #2;
    areset = 1'b1;
    #1;
    checks++;
    if (out_tvalid !== 1'b0) begin errors++; $display("FAIL midrst_tvalid: got %b want 0", out_tvalid); end
    checks++;
    if ({out_tdata, out_tkeep, out_tlast, out_tuser, out_tid} !== 78'd0) begin
      errors++; $display("FAIL midrst_outputs: got d=%h k=%h l=%b u=%b tid=%h want all 0",
                         out_tdata, out_tkeep, out_tlast, out_tuser, out_tid);
    end
    in_tvalid = 1'b0;
    @(posedge aclk);
    #1;
    areset = 1'b0;
    idle(1);
    push_exp(501, 7, 4'd9);
    fork
      drive_pkt(501, 7, 4'd9, 1'b0);
      collect(7, 100);
    join
    checks++;
    if (obs_q.size() != 7) begin errors++; $display("FAIL midrst_count: got %0d beats want 7", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL midrst_beat %0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    idle(2);
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_runt();
    test_truncate();
    test_max_legal();
    test_random_stall();
    test_reset_midpacket();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
